can_frame_field_sequencer: RTL and testbench
============================================

// Module: can_frame_field_sequencer
// PURPOSE
//  Tracks the field position of every received CAN 2.0A/2.0B frame and produces
//  field-enable strobes for the per-field checkers (stuff, CRC, ACK, EOF error blocks).
//  Sits between the bit-timing/destuff front end and the error blocks.
//  Also generates the active-low EOF window flag consumed by the EOF error checker.
//  All outputs describe the field of the bit sampled at the NEXT sample_en.
// PARAMETERS
//  IDLE_RECESSIVE  11  consecutive recessive bits required for bus integration / error recovery
//  MAX_DATA_BYTES  8   cap on data length; DLC values 9..15 map to this many bytes
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high
//  sample_en    in   1  one-clk strobe at each bit sample point
//  rx_bit       in   1  sampled bus bit (1 = recessive)
//  stuff_bit    in   1  current sample is a stuff bit (valid only with sample_en)
//  error_in     in   1  OR of all error-detector outputs, sampled with sample_en
//  field        out  4  current field code (see BEHAVIOUR)
//  eof_flag_n   out  1  0 while the next sampled bit is an EOF bit
//  stuff_chk_en out  1  1 from SOF through the last CRC bit
//  crc_chk_en   out  1  one-sample pulse: next sample is CRC delimiter
//  ack_slot     out  1  1 while next sampled bit is the ACK slot
//  ide          out  1  latched IDE bit of the current frame
//  rtr          out  1  latched RTR bit (SRR ignored)
//  dlc          out  4  latched DLC
//  frame_done   out  1  one-clk pulse after the last IFS bit of an error-free frame
// BEHAVIOUR
//  - Reset: state=INTEG; field=0; eof_flag_n=1; stuff_chk_en=0; crc_chk_en=0;
//    ack_slot=0; ide=0; rtr=0; dlc=0; frame_done=0; bit counter=0.
//  - State advances only on clk edges where sample_en=1; otherwise it holds.
//  - Stuff bits (stuff_bit=1) during SOF..CRC are ignored: no advance, no latch.
//    After CRC, stuff_bit is ignored entirely.
//  - Field codes and widths:
//      0 INTEG  : integrate until IDLE_RECESSIVE consecutive recessive bits
//      1 IDLE   : bus idle
//      2 SOF    : 1 bit
//      3 ID_A   : 11 bits
//      4 SRR_RTR: 1 bit
//      5 IDE    : 1 bit
//      6 ID_B   : 18 bits (taken only if IDE=1)
//      7 RTR_X  : 1 bit (extended frames only)
//      8 RES    : 1 bit r0 (standard) or 2 bits r1,r0 (extended)
//      9 DLC    : 4 bits, MSB first
//     10 DATA   : 8*min(dlc,MAX_DATA_BYTES) bits; skipped if rtr=1 or length=0
//     11 CRC    : 15 bits
//     12 CRCDEL : 1 bit
//     13 ACK    : 1 bit
//     14 ACKDEL : 1 bit
//     15 EOF    : 7 bits, then IFS of 3 bits. field=1 during IFS; internal substate.
//  - In INTEG: recessive sample increments the counter; dominant sample clears it.
//    At the count reaching IDLE_RECESSIVE -> IDLE.
//  - In IDLE: a dominant sample moves the sequencer so the next field is ID_A.
//    The dominant bit itself is the SOF, so SOF is a single-sample field code.
//  - rtr/ide latch:
//      standard: rtr = SRR_RTR bit;
//      extended: rtr = RTR_X bit.
//    ide, rtr and dlc are cleared on entry to SOF.
//  - eof_flag_n goes 0 on the sample that ends ACKDEL.
//    It returns to 1 on the sample that ends the 7th EOF bit.
//  - IFS: a dominant bit in any IFS position -> SOF of the next frame (overload not
//    handled). frame_done pulses when the 3rd IFS bit completes; next state IDLE.
//  - error_in=1 with sample_en=1 in any state except INTEG/IDLE -> INTEG with counter=0.
//    eof_flag_n=1 and all strobes are cleared on the same edge; frame_done is not asserted.
//  - error_in has priority over stuff_bit and over the normal transition.
//  - Async reset mid-frame returns immediately to reset values.
//  - Bit counter width is 5 bits; it is reloaded at every field boundary.
// TESTING
//  - Integration: reset, then 10 recessive samples -> still INTEG.
//    11th sample -> field=1.
//  - Std data frame: ID=0x123, RTR=0, DLC=2, 2 data bytes.
//    -> ide=0, dlc=2, eof_flag_n low for exactly 7 samples.
//    -> frame_done 1 clk after 3rd IFS bit.
//  - Ext remote frame: IDE=1, RTR_X=1, DLC=8 -> DATA skipped; CRC entered after DLC; rtr=1.
//  - Stuff bits: insert stuff_bit=1 samples inside ID_A and CRC.
//    -> field/counter unchanged on those samples; EOF timing identical to the unstuffed case.
//  - error_in pulse during 3rd EOF bit -> eof_flag_n=1 next edge, field=0.
//    -> no frame_done; 11 recessive samples required to reach IDLE.
//  - DLC=15 -> 64 DATA samples; dominant in 2nd IFS bit -> new SOF; ide/rtr/dlc cleared.

Source files
------------

// File: rtl/can_frame_field_sequencer.sv
// can_frame_field_sequencer: tracks CAN 2.0A/2.0B field position and drives per-field checker enables.
module can_frame_field_sequencer #(
  parameter int IDLE_RECESSIVE = 11,
  parameter int MAX_DATA_BYTES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       rx_bit,
  input  logic       stuff_bit,
  input  logic       error_in,
  output logic [3:0] field,
  output logic       eof_flag_n,
  output logic       stuff_chk_en,
  output logic       crc_chk_en,
  output logic       ack_slot,
  output logic       ide,
  output logic       rtr,
  output logic [3:0] dlc,
  output logic       frame_done
);
  typedef enum logic [4:0] {
    S_INTEG, S_IDLE, S_SOF, S_ID_A, S_SRR_RTR, S_IDE, S_ID_B, S_RTR_X, S_RES,
    S_DLC, S_DATA, S_CRC, S_CRCDEL, S_ACK, S_ACKDEL, S_EOF, S_IFS
  } state_t;
  state_t     r_state, w_nxt;
  logic [4:0] r_cnt, w_cnt, w_len;
  logic [2:0] r_byte, w_byte;
  logic [3:0] w_dlc_sh, w_nb, w_nb_sh, w_dlc;
  logic       w_ide, w_rtr, w_done, w_last, w_stf_zone, w_byte_end;
  assign w_dlc_sh   = {dlc[2:0], rx_bit};
  assign w_nb       = dlc > 4'(MAX_DATA_BYTES) ? 4'(MAX_DATA_BYTES) : dlc;
  assign w_nb_sh    = w_dlc_sh > 4'(MAX_DATA_BYTES) ? 4'(MAX_DATA_BYTES) : w_dlc_sh;
  assign w_stf_zone = r_state >= S_ID_A && r_state <= S_CRC;
  // Field length minus one; DATA is tracked as bit-in-byte plus byte index.
  assign w_len = r_state == S_ID_A ? 5'd10 :
                 r_state == S_ID_B ? 5'd17 :
                 r_state == S_RES  ? {4'd0, ide} :
                 r_state == S_DLC  ? 5'd3  :
                 r_state == S_CRC  ? 5'd14 :
                 r_state == S_EOF  ? 5'd6  :
                 r_state == S_IFS  ? 5'd2  : 5'd0;
  assign w_byte_end = r_state == S_DATA && r_cnt == 5'd7;
  assign w_last = r_state == S_DATA ? w_byte_end && r_byte == 3'(w_nb - 4'd1) : r_cnt == w_len;
  always_comb begin
    w_nxt  = r_state;
    w_cnt  = r_cnt;
    w_byte = r_byte;
    w_ide  = ide;
    w_rtr  = rtr;
    w_dlc  = dlc;
    w_done = 1'b0;
    if (sample_en) begin
      if (error_in && r_state != S_INTEG && r_state != S_IDLE) begin
        w_nxt  = S_INTEG;
        w_cnt  = 5'd0;
        w_byte = 3'd0;
      end else if (r_state == S_INTEG) begin
        w_cnt = rx_bit ? r_cnt + 5'd1 : 5'd0;
        if (rx_bit && r_cnt == 5'(IDLE_RECESSIVE - 1)) begin
          w_nxt = S_IDLE;
          w_cnt = 5'd0;
        end
      end else if ((r_state == S_IDLE || r_state == S_IFS) && !rx_bit) begin
        w_nxt  = S_ID_A;
        w_cnt  = 5'd0;
        w_byte = 3'd0;
        w_ide  = 1'b0;
        w_rtr  = 1'b0;
        w_dlc  = 4'd0;
      end else if (r_state != S_IDLE && !(stuff_bit && w_stf_zone)) begin
        w_cnt  = (w_last || w_byte_end) ? 5'd0 : r_cnt + 5'd1;
        w_byte = (w_byte_end && !w_last) ? r_byte + 3'd1 : (r_state == S_DATA && !w_last ? r_byte : 3'd0);
        w_rtr  = (r_state == S_SRR_RTR || r_state == S_RTR_X) ? rx_bit : rtr;
        w_ide  = r_state == S_IDE ? rx_bit : ide;
        w_dlc  = r_state == S_DLC ? w_dlc_sh : dlc;
        w_done = r_state == S_IFS && w_last;
        if (w_last)
          case (r_state)
            S_ID_A:    w_nxt = S_SRR_RTR;
            S_SRR_RTR: w_nxt = S_IDE;
            S_IDE:     w_nxt = rx_bit ? S_ID_B : S_RES;
            S_ID_B:    w_nxt = S_RTR_X;
            S_RTR_X:   w_nxt = S_RES;
            S_RES:     w_nxt = S_DLC;
            S_DLC:     w_nxt = (rtr || w_nb_sh == 4'd0) ? S_CRC : S_DATA;
            S_DATA:    w_nxt = S_CRC;
            S_CRC:     w_nxt = S_CRCDEL;
            S_CRCDEL:  w_nxt = S_ACK;
            S_ACK:     w_nxt = S_ACKDEL;
            S_ACKDEL:  w_nxt = S_EOF;
            S_EOF:     w_nxt = S_IFS;
            default:   w_nxt = S_IDLE;
          endcase
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_INTEG;
      r_cnt        <= 5'd0;
      r_byte       <= 3'd0;
      field        <= 4'd0;
      eof_flag_n   <= 1'b1;
      stuff_chk_en <= 1'b0;
      crc_chk_en   <= 1'b0;
      ack_slot     <= 1'b0;
      ide          <= 1'b0;
      rtr          <= 1'b0;
      dlc          <= 4'd0;
      frame_done   <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_cnt        <= w_cnt;
      r_byte       <= w_byte;
      field        <= w_nxt == S_IFS ? 4'd1 : w_nxt[3:0];
      eof_flag_n   <= w_nxt != S_EOF;
      stuff_chk_en <= w_nxt >= S_ID_A && w_nxt <= S_CRC;
      crc_chk_en   <= w_nxt == S_CRCDEL;
      ack_slot     <= w_nxt == S_ACK;
      ide          <= w_ide;
      rtr          <= w_rtr;
      dlc          <= w_dlc;
      frame_done   <= w_done;
    end
  end
endmodule

// File: tb/tb_can_frame_field_sequencer.sv
// tb_can_frame_field_sequencer: directed-step bench for the CAN field sequencer.
module tb_can_frame_field_sequencer;
  logic clk = 1'b0, reset = 1'b1, sample_en = 1'b0, rx_bit = 1'b1, stuff_bit = 1'b0, error_in = 1'b0;
  logic [3:0] field, dlc;
  logic eof_flag_n, stuff_chk_en, crc_chk_en, ack_slot, ide, rtr, frame_done;
  int checks = 0, failures = 0, n;
  can_frame_field_sequencer dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .rx_bit(rx_bit), .stuff_bit(stuff_bit),
    .error_in(error_in), .field(field), .eof_flag_n(eof_flag_n), .stuff_chk_en(stuff_chk_en),
    .crc_chk_en(crc_chk_en), .ack_slot(ack_slot), .ide(ide), .rtr(rtr), .dlc(dlc),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic smp(input logic rx, input logic st, input logic er);
    @(negedge clk);
    rx_bit = rx; stuff_bit = st; error_in = er; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0; stuff_bit = 1'b0; error_in = 1'b0; rx_bit = 1'b1;
  endtask
  task automatic send(input logic [63:0] v, input int cnt);
    for (int i = cnt - 1; i >= 0; i--) smp(v[i], 1'b0, 1'b0);
  endtask
  task automatic eof_count(output int c);
    c = 0;
    while (!eof_flag_n && c < 12) begin
      smp(1'b1, 1'b0, 1'b0);
      c++;
    end
  endtask
  task automatic std_frame(input logic stf);
    smp(1'b0, 1'b0, 1'b0);
    chk("sof_field", field, 3);
    chk("sof_stuff_en", stuff_chk_en, 1);
    send(64'h123 >> 6, 5);
    if (stf) begin
      smp(1'b1, 1'b1, 1'b0);
      chk("stuff_ida_hold", field, 3);
    end
    send(64'h123, 6);
    chk("ida_end", field, 4);
    smp(1'b0, 1'b0, 1'b0);
    chk("rtr_end", field, 5);
    smp(1'b0, 1'b0, 1'b0);
    chk("ide_std", field, 8);
    smp(1'b0, 1'b0, 1'b0);
    chk("r0_end", field, 9);
    send(64'h2, 4);
    chk("dlc_end_field", field, 10);
    chk("dlc_val", dlc, 2);
    chk("ide_val", ide, 0);
    chk("rtr_val", rtr, 0);
    send(64'hA53C >> 1, 15);
    chk("data_15", field, 10);
    smp(1'b0, 1'b0, 1'b0);
    chk("data_16", field, 11);
    send(64'h4D2A >> 8, 7);
    if (stf) begin
      smp(1'b0, 1'b1, 1'b0);
      chk("stuff_crc_hold", field, 11);
    end
    chk("crc_mid", field, 11);
    send(64'h4D2A, 8);
    chk("crc_end", field, 12);
    chk("crc_chk_en", crc_chk_en, 1);
    chk("stuff_en_off", stuff_chk_en, 0);
    smp(1'b1, 1'b0, 1'b0);
    chk("ack_slot_on", ack_slot, 1);
    chk("crcdel_end", field, 13);
    smp(1'b0, 1'b0, 1'b0);
    chk("ack_end", field, 14);
    chk("ack_slot_off", ack_slot, 0);
    smp(1'b1, 1'b0, 1'b0);
    chk("ackdel_end", field, 15);
    chk("eof_low", eof_flag_n, 0);
    eof_count(n);
    chk("eof_len", n, 7);
    chk("ifs_field", field, 1);
    smp(1'b1, 1'b0, 1'b0);
    smp(1'b1, 1'b0, 1'b0);
    chk("done_early", frame_done, 0);
    smp(1'b1, 1'b0, 1'b0);
    chk("done_pulse", frame_done, 1);
    chk("idle_after", field, 1);
    @(negedge clk);
    chk("done_clear", frame_done, 0);
  endtask
  initial begin
    #12;
    chk("rst_field", field, 0);
    chk("rst_outs", {eof_flag_n, stuff_chk_en, crc_chk_en, ack_slot, ide, rtr, dlc, frame_done}, 11'h400);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) smp(1'b1, 1'b0, 1'b0);
    chk("integ_10", field, 0);
    smp(1'b1, 1'b0, 1'b0);
    chk("integ_11", field, 1);
    std_frame(1'b0);
    std_frame(1'b1);
    // Extended remote frame, aborted by an error in the 3rd EOF bit.
    smp(1'b0, 1'b0, 1'b0);
    send(64'h555, 11);
    chk("ext_ida", field, 4);
    smp(1'b1, 1'b0, 1'b0);
    smp(1'b1, 1'b0, 1'b0);
    chk("ext_idb", field, 6);
    chk("ext_ide", ide, 1);
    send(64'h2AAAA, 18);
    chk("ext_rtrx", field, 7);
    smp(1'b1, 1'b0, 1'b0);
    chk("ext_res", field, 8);
    chk("ext_rtr", rtr, 1);
    smp(1'b0, 1'b0, 1'b0);
    chk("ext_res2", field, 8);
    smp(1'b0, 1'b0, 1'b0);
    chk("ext_dlc", field, 9);
    send(64'h8, 4);
    chk("ext_skip_data", field, 11);
    chk("ext_dlc_val", dlc, 8);
    send(64'h1111, 15);
    smp(1'b1, 1'b0, 1'b0);
    smp(1'b0, 1'b0, 1'b0);
    smp(1'b1, 1'b0, 1'b0);
    smp(1'b1, 1'b0, 1'b0);
    smp(1'b1, 1'b0, 1'b0);
    chk("ext_eof3", {field, eof_flag_n}, {4'd15, 1'b0});
    smp(1'b1, 1'b0, 1'b1);
    chk("err_eof", eof_flag_n, 1);
    chk("err_field", field, 0);
    chk("err_done", frame_done, 0);
    for (int i = 0; i < 10; i++) smp(1'b1, 1'b0, 1'b0);
    chk("reinteg_10", field, 0);
    smp(1'b1, 1'b0, 1'b0);
    chk("reinteg_11", field, 1);
    // Extended data frame with DLC=15, then a new SOF in the 2nd IFS bit.
    smp(1'b0, 1'b0, 1'b0);
    send(64'h3A5, 11);
    smp(1'b1, 1'b0, 1'b0);
    smp(1'b1, 1'b0, 1'b0);
    send(64'h15555, 18);
    smp(1'b0, 1'b0, 1'b0);
    chk("d15_rtr", rtr, 0);
    smp(1'b0, 1'b0, 1'b0);
    smp(1'b0, 1'b0, 1'b0);
    send(64'hF, 4);
    chk("d15_field", field, 10);
    chk("d15_dlc", dlc, 15);
    for (int i = 0; i < 63; i++) smp(i[0], 1'b0, 1'b0);
    chk("d15_63", field, 10);
    smp(1'b1, 1'b0, 1'b0);
    chk("d15_64", field, 11);
    send(64'h2222, 15);
    smp(1'b1, 1'b0, 1'b0);
    smp(1'b0, 1'b0, 1'b0);
    smp(1'b1, 1'b0, 1'b0);
    eof_count(n);
    chk("d15_eof_len", n, 7);
    smp(1'b1, 1'b0, 1'b0);
    smp(1'b0, 1'b0, 1'b0);
    chk("ifs_sof_field", field, 3);
    chk("ifs_sof_clr", {ide, rtr, dlc}, 0);
    chk("ifs_sof_done", frame_done, 0);
    send(64'h7, 5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_field", field, 0);
    chk("async_rst_stuff", stuff_chk_en, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
